// File: rtl/scr1_tcm_port_arb_pkg.sv
// rtl/scr1_tcm_port_arb_pkg.sv - shared native memory-interface command, width and response encodings
package scr1_tcm_port_arb_pkg;

    typedef enum logic {
        MEM_CMD_RD = 1'b0,
        MEM_CMD_WR = 1'b1
    } mem_cmd_e;

    typedef enum logic [1:0] {
        MEM_WIDTH_BYTE = 2'b00,
        MEM_WIDTH_HALF = 2'b01,
        MEM_WIDTH_WORD = 2'b10,
        MEM_WIDTH_RSVD = 2'b11
    } mem_width_e;

    typedef enum logic [1:0] {
        MEM_RESP_IDLE   = 2'b00,
        MEM_RESP_RDY_OK = 2'b01,
        MEM_RESP_RDY_ER = 2'b10,
        MEM_RESP_NOTRDY = 2'b11
    } mem_resp_e;

endpackage

// File: rtl/scr1_tcm_port_arb_lane_align.sv
// rtl/scr1_tcm_port_arb_lane_align.sv - scr1_tcm_lane_align: byte enables, write/read lane shifting, misalignment
module scr1_tcm_lane_align
    import scr1_tcm_port_arb_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic        misaligned,
    input  logic [1:0]  rd_width,
    input  logic [1:0]  rd_off,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_sh
);

    logic [31:0] rdata_lsb;

    always_comb begin
        be         = 4'b0000;
        misaligned = 1'b0;
        case (mem_width_e'(width))
            MEM_WIDTH_BYTE: be = 4'b0001 << off;
            MEM_WIDTH_HALF: begin
                be         = 4'b0011 << off;
                misaligned = off[0];
            end
            MEM_WIDTH_WORD: begin
                be         = 4'b1111;
                misaligned = |off;
            end
            default: misaligned = 1'b1;
        endcase
    end

    assign wdata_sh  = wdata << {off, 3'b000};
    assign rdata_lsb = rdata >> {rd_off, 3'b000};

    always_comb begin
        rdata_sh = rdata_lsb;
        case (mem_width_e'(rd_width))
            MEM_WIDTH_BYTE: rdata_sh = {24'h0, rdata_lsb[7:0]};
            MEM_WIDTH_HALF: rdata_sh = {16'h0, rdata_lsb[15:0]};
            default:        rdata_sh = rdata_lsb;
        endcase
    end

endmodule

// File: rtl/scr1_tcm_port_arb.sv
// rtl/scr1_tcm_port_arb.sv - imem/dmem arbiter onto one single-port TCM SRAM bank
module scr1_tcm_port_arb
    import scr1_tcm_port_arb_pkg::*;
#(
    parameter int unsigned TCM_SIZE_BYTES = 65536,
    parameter int unsigned STARVE_MAX     = 4,
    localparam int unsigned ADDR_W        = $clog2(TCM_SIZE_BYTES / 4)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_req,
    input  logic [31:0]       imem_addr,
    output logic              imem_req_ack,
    output logic [31:0]       imem_rdata,
    output logic [1:0]        imem_resp,
    input  logic              dmem_req,
    input  logic              dmem_cmd,
    input  logic [1:0]        dmem_width,
    input  logic [31:0]       dmem_addr,
    input  logic [31:0]       dmem_wdata,
    output logic              dmem_req_ack,
    output logic [31:0]       dmem_rdata,
    output logic [1:0]        dmem_resp,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [3:0]        sram_be,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic       live;
    logic       open;
    logic [3:0] starve_cnt;
    logic       d_misaligned, d_err, i_err, d_ok, i_ok, grant_i, grant_d;
    logic [3:0] d_be;
    logic [31:0] d_rdata_sh;

    logic       i_rv, i_re;
    logic       d_rv, d_re, d_wr;
    logic [1:0] d_off, d_width;

    scr1_tcm_lane_align u_lane (
        .width      (dmem_width),
        .off        (dmem_addr[1:0]),
        .wdata      (dmem_wdata),
        .be         (d_be),
        .wdata_sh   (sram_wdata),
        .misaligned (d_misaligned),
        .rd_width   (d_width),
        .rd_off     (d_off),
        .rdata      (sram_rdata),
        .rdata_sh   (d_rdata_sh)
    );

    // Nothing is accepted during reset nor in the first cycle after it.
    assign open  = live & ~rst;
    assign d_err = open & dmem_req & d_misaligned;
    assign i_err = open & imem_req & (imem_addr[1:0] != 2'b00);
    assign d_ok  = open & dmem_req & ~d_misaligned;
    assign i_ok  = open & imem_req & (imem_addr[1:0] == 2'b00);

    assign grant_i = i_ok & (~d_ok | (starve_cnt == STARVE_LIM));
    assign grant_d = d_ok & ~grant_i;

    assign imem_req_ack = grant_i | i_err;
    assign dmem_req_ack = grant_d | d_err;

    assign sram_ce   = grant_i | grant_d;
    assign sram_we   = grant_d & dmem_cmd;
    assign sram_be   = grant_d ? d_be : (grant_i ? 4'b1111 : 4'b0000);
    assign sram_addr = grant_i ? imem_addr[ADDR_W+1:2] : dmem_addr[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            live       <= 1'b0;
            starve_cnt <= 4'd0;
            i_rv       <= 1'b0;
            i_re       <= 1'b0;
            d_rv       <= 1'b0;
            d_re       <= 1'b0;
            d_wr       <= 1'b0;
            d_off      <= 2'b00;
            d_width    <= 2'b00;
        end else begin
            live    <= 1'b1;
            i_rv    <= imem_req_ack;
            i_re    <= i_err;
            d_rv    <= dmem_req_ack;
            d_re    <= d_err;
            d_wr    <= dmem_cmd;
            d_off   <= dmem_addr[1:0];
            d_width <= dmem_width;
            if (!imem_req || imem_req_ack) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // A response due while reset is asserted is dropped rather than delivered.
    always_comb begin
        imem_resp  = MEM_RESP_IDLE;
        imem_rdata = 32'h0;
        dmem_resp  = MEM_RESP_IDLE;
        dmem_rdata = 32'h0;
        if (!rst && i_rv) begin
            imem_resp  = i_re ? MEM_RESP_RDY_ER : MEM_RESP_RDY_OK;
            imem_rdata = i_re ? 32'h0 : sram_rdata;
        end
        if (!rst && d_rv) begin
            dmem_resp  = d_re ? MEM_RESP_RDY_ER : MEM_RESP_RDY_OK;
            dmem_rdata = (d_re || d_wr) ? 32'h0 : d_rdata_sh;
        end
    end

endmodule

// File: tb/tb_scr1_tcm_port_arb.sv
// tb/tb_scr1_tcm_port_arb.sv - randomized self-checking bench for scr1_tcm_port_arb
module tb_scr1_tcm_port_arb;

    localparam int SIZE   = 65536;
    localparam int SMAX   = 4;
    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              imem_req = 1'b0;
    logic [31:0]       imem_addr = '0;
    logic              imem_req_ack;
    logic [31:0]       imem_rdata;
    logic [1:0]        imem_resp;
    logic              dmem_req = 1'b0;
    logic              dmem_cmd = 1'b0;
    logic [1:0]        dmem_width = '0;
    logic [31:0]       dmem_addr = '0;
    logic [31:0]       dmem_wdata = '0;
    logic              dmem_req_ack;
    logic [31:0]       dmem_rdata;
    logic [1:0]        dmem_resp;
    logic              sram_ce;
    logic              sram_we;
    logic [3:0]        sram_be;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata = '0;

    scr1_tcm_port_arb #(.TCM_SIZE_BYTES(SIZE), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_req_ack(imem_req_ack),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req_ack(dmem_req_ack),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM macro stand-in
    logic [31:0] sram_mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    // Reference model state: byte-addressed bank contents and expected responses
    byte unsigned ref_mem [0:SIZE-1];
    int          losses = 0;
    bit          prev_rst = 1'b1;
    logic [1:0]  exp_iresp = 2'd0, exp_dresp = 2'd0;
    logic [31:0] exp_irdata = '0, exp_drdata = '0;
    bit          last_iack = 0, last_dack = 0;
    int          iack_cnt = 0;
    int          n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int base);
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    endfunction

    task automatic step(input bit r, input bit ir, input logic [31:0] ia,
                        input bit dr, input bit dc, input logic [1:0] dw,
                        input logic [31:0] da, input logic [31:0] dwd);
        int  off, nbytes, dbyte, ibyte, exp_be;
        bit  blocked, d_bad, i_bad, d_ok, i_ok, gi, gd;
        logic [31:0] mask, val;
        @(negedge clk);
        rst = r; imem_req = ir; imem_addr = ia;
        dmem_req = dr; dmem_cmd = dc; dmem_width = dw; dmem_addr = da; dmem_wdata = dwd;
        #1;
        check("imem_resp", 32'(imem_resp), r ? 32'd0 : 32'(exp_iresp));
        check("imem_rdata", imem_rdata, r ? 32'd0 : exp_irdata);
        check("dmem_resp", 32'(dmem_resp), r ? 32'd0 : 32'(exp_dresp));
        check("dmem_rdata", dmem_rdata, r ? 32'd0 : exp_drdata);

        blocked = r || prev_rst;
        off    = int'(da % 4);
        nbytes = (dw == 2'd0) ? 1 : (dw == 2'd1) ? 2 : 4;
        d_bad  = dr && (dw == 2'd3 || (off % nbytes) != 0);
        i_bad  = ir && (ia % 4) != 0;
        d_ok   = dr && !d_bad;
        i_ok   = ir && !i_bad;
        gi     = !blocked && i_ok && (!d_ok || losses == SMAX);
        gd     = !blocked && d_ok && !gi;
        check("imem_req_ack", 32'(imem_req_ack), 32'(gi || (!blocked && i_bad)));
        check("dmem_req_ack", 32'(dmem_req_ack), 32'(gd || (!blocked && d_bad)));
        check("sram_ce", 32'(sram_ce), 32'(gi || gd));
        dbyte  = int'(da % SIZE);
        ibyte  = int'(ia % SIZE);
        exp_be = (((1 << nbytes) - 1) << off) & 15;
        if (gd) begin
            check("sram_we", 32'(sram_we), 32'(dc));
            check("sram_be", 32'(sram_be), 32'(exp_be));
            check("sram_addr_d", 32'(sram_addr), 32'(dbyte / 4));
            if (dc) for (int k = 0; k < nbytes; k++)
                check("sram_wdata_lane", 32'(sram_wdata[8*(off+k) +: 8]), (dwd >> (8*k)) & 32'hFF);
        end else if (gi) begin
            check("sram_we_i", 32'(sram_we), 32'd0);
            check("sram_addr_i", 32'(sram_addr), 32'(ibyte / 4));
        end else begin
            check("sram_we_idle", 32'(sram_we), 32'd0);
            check("sram_be_idle", 32'(sram_be), 32'd0);
        end

        exp_iresp = 2'd0; exp_irdata = '0; exp_dresp = 2'd0; exp_drdata = '0;
        if (!r) begin
            if (gi) begin
                exp_iresp = 2'd1; exp_irdata = ref_word(ibyte);
            end else if (!blocked && i_bad) begin
                exp_iresp = 2'd2;
            end
            if (gd) begin
                exp_dresp = 2'd1;
                if (dc) begin
                    for (int k = 0; k < nbytes; k++) ref_mem[dbyte + k] = 8'((dwd >> (8*k)) & 32'hFF);
                end else begin
                    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nbytes)) - 32'd1);
                    val  = ref_word(dbyte - off) >> (8*off);
                    exp_drdata = val & mask;
                end
            end else if (!blocked && d_bad) begin
                exp_dresp = 2'd2;
            end
        end
        if (r || !ir || gi || (!blocked && i_bad)) losses = 0;
        else if (losses < SMAX) losses++;
        prev_rst  = r;
        last_iack = gi || (!blocked && i_bad);
        last_dack = gd || (!blocked && d_bad);
        if (last_iack) iack_cnt++;
    endtask

    initial begin
        bit          ir, dr, dc;
        logic [31:0] ia, da, dwd;
        logic [1:0]  dw;
        int          base_cnt;
        for (int i = 0; i < (1 << ADDR_W); i++) sram_mem[i] = '0;
        for (int i = 0; i < SIZE; i++) ref_mem[i] = 8'h00;

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 32'h40, 1, 1, 2, 32'h100, 32'h1234_5678);
        step(0, 0, 0, 1, 1, 2, 32'h100, 32'hDEAD_BEEF);
        step(0, 0, 0, 1, 1, 2, 32'h100, 32'hDEAD_BEEF);
        check("word_write_be", 32'(last_dack), 32'd1);
        step(0, 0, 0, 1, 0, 0, 32'h102, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("byte_read_0x102", dmem_rdata, 32'h0000_00AD);
        step(0, 0, 0, 1, 1, 1, 32'h206, 32'h0000_ABCD);
        step(0, 0, 0, 1, 0, 1, 32'h205, 0);
        step(0, 0, 0, 1, 0, 1, 32'h204, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("half_read_0x206", dmem_rdata, 32'h0000_0000);
        step(0, 0, 0, 1, 0, 1, 32'h206, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("half_read_back", dmem_rdata, 32'h0000_ABCD);

        base_cnt = iack_cnt;
        for (int c = 0; c < 10; c++) step(0, 1, 32'h40, 1, 0, 2, 32'h80, 0);
        check("starve_imem_grants", 32'(iack_cnt - base_cnt), 32'd2);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h100, 1, 0, 2, 32'h3, 0);
        check("both_acked", 32'({last_iack, last_dack}), 32'b11);
        step(0, 0, 0, 1, 0, 2, 32'h0001_0010, 0);
        step(0, 0, 0, 1, 1, 2, 32'h0003_0104, 32'hCAFE_F00D);
        step(1, 0, 0, 1, 1, 2, 32'h108, 32'h5555_5555);
        step(1, 0, 0, 1, 1, 2, 32'h108, 32'h5555_5555);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h104, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("alias_write_read", imem_rdata, 32'hCAFE_F00D);

        ir = 0; dr = 0; ia = '0; da = '0; dc = 0; dw = '0; dwd = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!(ir && !last_iack)) begin
                ir = ($urandom_range(0, 2) != 0);
                ia = (32'($urandom_range(0, 3)) << 16) | (32'($urandom_range(0, 63)) & ~32'h3);
                if ($urandom_range(0, 7) == 0) ia = ia | 32'($urandom_range(1, 3));
            end
            if (!(dr && !last_dack)) begin
                dr  = ($urandom_range(0, 2) != 0);
                dc  = $urandom_range(0, 1) != 0;
                dw  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                da  = (32'($urandom_range(0, 3)) << 16) | 32'($urandom_range(0, 63));
                if ($urandom_range(0, 3) != 0)
                    da = (dw == 2'd2) ? (da & ~32'h3) : (dw == 2'd1) ? (da & ~32'h1) : da;
                dwd = $urandom;
            end
            step($urandom_range(0, 299) == 0, ir, ia, dr, dc, dw, da, dwd);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
